// File: rtl/cpu_pkg.sv
//==============================================================================
// Module : cpu_pkg
// Brief  : Opcodes, ALU codes, sequencer state encoding and decode helpers.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    // T-states are numbered consecutively so that "next T-state" is +1.
    typedef logic [3:0] state_t;
    localparam state_t RESET_S = 4'd0;
    localparam state_t T0      = 4'd1;
    localparam state_t T1      = 4'd2;
    localparam state_t T2      = 4'd3;
    localparam state_t T3      = 4'd4;
    localparam state_t T4      = 4'd5;
    localparam state_t T5      = 4'd6;
    localparam state_t T6      = 4'd7;
    localparam state_t T7      = 4'd8;
    localparam state_t HALT_S  = 4'd9;

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_ADD;
        endcase
    endfunction

    // Final T-state of each instruction; nop and undefined opcodes end after fetch.
    function automatic state_t last_state(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                                   return T7;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI,
            OP_ORI:                                         return T5;
            OP_MUL, OP_DIV, OP_BR:                          return T6;
            OP_NEG, OP_NOT, OP_JAL:                         return T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
            OP_HALT:                                        return T3;
            default:                                        return T2;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s, input logic [4:0] op);
        return (s == T1) || (s == T6 && op == OP_LD) || (s == T7 && op == OP_ST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
//==============================================================================
// Module : mem_wait_counter
// Brief  : Loadable 3-bit down-counter that stretches memory T-states.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    output logic [2:0] o_count,
    output logic       o_done
);

    logic [2:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 3'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 3'd0) begin
            r_count <= r_count - 3'd1;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == 3'd0);

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
//==============================================================================
// Module : control_sequencer
// Brief  : Hardwired Moore control unit for the 32-bit single-bus datapath.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module control_sequencer #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        Branch,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        Rin,
    output logic        Rout,
    output logic        GRA,
    output logic        GRB,
    output logic        GRC,
    output logic        IncPc,
    output logic        read,
    output logic        write,
    output logic [1:0]  mdr_read,
    output logic [3:0]  control,
    output logic        run
);

    import cpu_pkg::*;

    localparam logic [2:0] c_WAIT = 3'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic       r_brflag;
    logic [4:0] w_op;
    logic [3:0] w_alu;
    state_t     w_last;
    logic       w_cur_mem;
    logic       w_load;
    logic [2:0] w_count;
    logic       w_done;
    logic       w_first;
    logic       w_is_rtype;
    logic       w_is_imm;
    logic       w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_unused_ir = ^IR[26:0];
    assign w_alu       = alu_code(w_op);
    assign w_last      = last_state(w_op);
    assign w_is_rtype  = (w_op >= OP_ADD) && (w_op <= OP_ROL);
    assign w_is_imm    = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
    assign w_cur_mem   = is_mem_state(r_state, w_op);
    assign w_load      = is_mem_state(w_next, w_op) && (w_next != r_state);
    assign w_first     = (w_count == c_WAIT);

    mem_wait_counter u_wait (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (c_WAIT),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET_S: w_next = T0;
            HALT_S:  w_next = HALT_S;
            default: begin
                if (w_cur_mem && !w_done) begin
                    w_next = r_state;
                end else if (r_state >= w_last) begin
                    w_next = (w_op == OP_HALT) ? HALT_S : T0;
                end else begin
                    w_next = r_state + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RESET_S;
            r_brflag <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == T3 && w_op == OP_BR) begin
                r_brflag <= Branch;
            end
        end
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; HIin = 1'b0; LOin = 1'b0;
        OutPortin = 1'b0; Rin = 1'b0; Rout = 1'b0; GRA = 1'b0; GRB = 1'b0;
        GRC = 1'b0; IncPc = 1'b0; read = 1'b0; write = 1'b0;
        mdr_read = 2'b00; control = ALU_ADD;
        run = (r_state != RESET_S) && (r_state != HALT_S);

        case (r_state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
            end
            T1: begin
                // The incremented PC is written back only once, however long the read lasts.
                read = 1'b1; mdr_read = 2'b01;
                if (w_first) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
                MDRin = w_done;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3, T4, T5, T6, T7: begin
                if (w_is_rtype || w_is_imm) begin
                    case (r_state)
                        T3: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        T4: begin
                            if (w_is_imm) begin
                                Cout = 1'b1;
                            end else begin
                                GRC = 1'b1; Rout = 1'b1;
                            end
                            control = w_alu; Zlowin = 1'b1;
                        end
                        T5: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end else begin
                    case (w_op)
                        OP_LD, OP_LDI, OP_ST: begin
                            case (r_state)
                                T3: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                                T4: begin Cout = 1'b1; control = ALU_ADD; Zlowin = 1'b1; end
                                T5: begin
                                    Zlowout = 1'b1;
                                    if (w_op == OP_LDI) begin
                                        GRA = 1'b1; Rin = 1'b1;
                                    end else begin
                                        MARin = 1'b1;
                                    end
                                end
                                T6: begin
                                    if (w_op == OP_LD) begin
                                        read = 1'b1; mdr_read = 2'b01; MDRin = w_done;
                                    end else if (w_op == OP_ST) begin
                                        GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                                    end
                                end
                                T7: begin
                                    if (w_op == OP_LD) begin
                                        MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                                    end else if (w_op == OP_ST) begin
                                        write = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        OP_MUL, OP_DIV: begin
                            case (r_state)
                                T3: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                T4: begin
                                    GRB = 1'b1; Rout = 1'b1; control = w_alu;
                                    Zlowin = 1'b1; Zhighin = 1'b1;
                                end
                                T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                                T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_NEG, OP_NOT: begin
                            case (r_state)
                                T3: begin GRB = 1'b1; Rout = 1'b1; control = w_alu; Zlowin = 1'b1; end
                                T4: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_BR: begin
                            // Condition was latched from Branch at the end of T3.
                            case (r_state)
                                T3: begin GRA = 1'b1; Rout = 1'b1; end
                                T4: begin PCout = 1'b1; Yin = 1'b1; end
                                T5: begin Cout = 1'b1; control = ALU_ADD; Zlowin = 1'b1; end
                                T6: begin Zlowout = r_brflag; PCin = r_brflag; end
                                default: ;
                            endcase
                        end
                        OP_JR: begin
                            if (r_state == T3) begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        end
                        OP_JAL: begin
                            if (r_state == T3) begin PCout = 1'b1; GRB = 1'b1; Rin = 1'b1; end
                            if (r_state == T4) begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        end
                        OP_IN: begin
                            if (r_state == T3) begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                        end
                        OP_OUT: begin
                            if (r_state == T3) begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                        end
                        OP_MFHI: begin
                            if (r_state == T3) begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                        end
                        OP_MFLO: begin
                            if (r_state == T3) begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//==============================================================================
// Module : tb_control_sequencer
// Brief  : Scoreboard bench for control_sequencer with directed instructions.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_control_sequencer;

    localparam int MW = 2;

    localparam logic [34:0] PCOUT     = 35'h1 << 0;
    localparam logic [34:0] ZLOWOUT   = 35'h1 << 1;
    localparam logic [34:0] ZHIGHOUT  = 35'h1 << 2;
    localparam logic [34:0] MDROUT    = 35'h1 << 3;
    localparam logic [34:0] HIOUT     = 35'h1 << 4;
    localparam logic [34:0] LOOUT     = 35'h1 << 5;
    localparam logic [34:0] INPORTOUT = 35'h1 << 6;
    localparam logic [34:0] COUT      = 35'h1 << 7;
    localparam logic [34:0] BAOUT     = 35'h1 << 8;
    localparam logic [34:0] PCIN      = 35'h1 << 9;
    localparam logic [34:0] MARIN     = 35'h1 << 10;
    localparam logic [34:0] MDRIN     = 35'h1 << 11;
    localparam logic [34:0] IRIN      = 35'h1 << 12;
    localparam logic [34:0] YIN       = 35'h1 << 13;
    localparam logic [34:0] ZLOWIN    = 35'h1 << 15;
    localparam logic [34:0] ZHIGHIN   = 35'h1 << 16;
    localparam logic [34:0] HIIN      = 35'h1 << 17;
    localparam logic [34:0] LOIN      = 35'h1 << 18;
    localparam logic [34:0] OUTPORTIN = 35'h1 << 19;
    localparam logic [34:0] RIN       = 35'h1 << 20;
    localparam logic [34:0] ROUT      = 35'h1 << 21;
    localparam logic [34:0] GRA       = 35'h1 << 22;
    localparam logic [34:0] GRB       = 35'h1 << 23;
    localparam logic [34:0] GRC       = 35'h1 << 24;
    localparam logic [34:0] INCPC     = 35'h1 << 25;
    localparam logic [34:0] READ      = 35'h1 << 26;
    localparam logic [34:0] WRITE     = 35'h1 << 27;
    localparam logic [34:0] MDRMEM    = 35'h1 << 28;
    localparam logic [34:0] RUN       = 35'h1 << 34;

    typedef struct {
        logic [34:0] v;
        int          tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] IR;
    logic        Branch;
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, Zlowin, Zhighin, HIin, LOin, OutPortin;
    logic Rin, Rout, GRAo, GRBo, GRCo, IncPc, read, write, run;
    logic [1:0]  mdr_read;
    logic [3:0]  control;
    logic [34:0] w_obs;

    exp_t        sb[$];
    logic [34:0] gl[$];
    exp_t        r_pop;
    int          total = 0;
    int          bad   = 0;
    int          id    = 0;

    control_sequencer #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .IR(IR), .Branch(Branch),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
        .Rin(Rin), .Rout(Rout), .GRA(GRAo), .GRB(GRBo), .GRC(GRCo), .IncPc(IncPc),
        .read(read), .write(write), .mdr_read(mdr_read), .control(control), .run(run)
    );

    assign w_obs = {run, control, mdr_read, write, read, IncPc, GRCo, GRBo, GRAo, Rout, Rin,
                    OutPortin, LOin, HIin, Zhighin, Zlowin, Zin, Yin, IRin, MDRin, MARin, PCin,
                    BAout, Cout, InPortout, LOout, HIout, MDRout, Zhighout, Zlowout, PCout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] ctl(input logic [3:0] c);
        return {1'b0, c, 30'd0};
    endfunction

    // Monitor: every cycle the DUT is running or strobing consumes one expectation.
    always @(negedge clk) begin
        if (w_obs !== 35'd0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe got=%h required=%h", w_obs, 35'd0);
            end else begin
                r_pop = sb.pop_front();
                if (w_obs !== r_pop.v) begin
                    bad++;
                    $display("FAIL step_%0d got=%h required=%h", r_pop.tag, w_obs, r_pop.v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [34:0] got, input logic [34:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic gen(input logic [4:0] op, input logic [3:0] alu, input logic br);
        gl.delete();
        gl.push_back(PCOUT | MARIN | INCPC | ZLOWIN);
        for (int i = 0; i <= MW; i++)
            gl.push_back(READ | MDRMEM | ((i == 0) ? (ZLOWOUT | PCIN) : 35'd0)
                         | ((i == MW) ? MDRIN : 35'd0));
        gl.push_back(MDROUT | IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
                gl.push_back(GRB | ROUT | YIN);
                gl.push_back(GRC | ROUT | ctl(alu) | ZLOWIN);
                gl.push_back(ZLOWOUT | GRA | RIN);
            end
            5'b01011, 5'b01100, 5'b01101: begin
                gl.push_back(GRB | ROUT | YIN);
                gl.push_back(COUT | ctl(alu) | ZLOWIN);
                gl.push_back(ZLOWOUT | GRA | RIN);
            end
            5'b00001: begin
                gl.push_back(GRB | BAOUT | YIN);
                gl.push_back(COUT | ZLOWIN);
                gl.push_back(ZLOWOUT | GRA | RIN);
            end
            5'b00000, 5'b00010: begin
                gl.push_back(GRB | BAOUT | YIN);
                gl.push_back(COUT | ZLOWIN);
                gl.push_back(ZLOWOUT | MARIN);
                if (op == 5'b00000) begin
                    for (int i = 0; i <= MW; i++)
                        gl.push_back(READ | MDRMEM | ((i == MW) ? MDRIN : 35'd0));
                    gl.push_back(MDROUT | GRA | RIN);
                end else begin
                    gl.push_back(GRA | ROUT | MDRIN);
                    for (int i = 0; i <= MW; i++) gl.push_back(WRITE);
                end
            end
            5'b01110, 5'b01111: begin
                gl.push_back(GRA | ROUT | YIN);
                gl.push_back(GRB | ROUT | ctl(alu) | ZLOWIN | ZHIGHIN);
                gl.push_back(ZLOWOUT | LOIN);
                gl.push_back(ZHIGHOUT | HIIN);
            end
            5'b10000, 5'b10001: begin
                gl.push_back(GRB | ROUT | ctl(alu) | ZLOWIN);
                gl.push_back(ZLOWOUT | GRA | RIN);
            end
            5'b10010: begin
                gl.push_back(GRA | ROUT);
                gl.push_back(PCOUT | YIN);
                gl.push_back(COUT | ZLOWIN);
                gl.push_back(br ? (ZLOWOUT | PCIN) : 35'd0);
            end
            5'b10011: gl.push_back(GRA | ROUT | PCIN);
            5'b10100: begin
                gl.push_back(PCOUT | GRB | RIN);
                gl.push_back(GRA | ROUT | PCIN);
            end
            5'b10101: gl.push_back(INPORTOUT | GRA | RIN);
            5'b10110: gl.push_back(GRA | ROUT | OUTPORTIN);
            5'b10111: gl.push_back(HIOUT | GRA | RIN);
            5'b11000: gl.push_back(LOOUT | GRA | RIN);
            5'b11010: gl.push_back(35'd0);
            default: ;
        endcase
    endtask

    // Called just after the edge into T0; returns just after the edge into the next state.
    task automatic do_instr(input logic [4:0] op, input logic [3:0] alu, input logic br, input int limit);
        int   n;
        exp_t e;
        gen(op, alu, br);
        n = gl.size();
        if (limit > 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            e.v   = gl[i] | RUN;
            e.tag = id * 100 + i;
            sb.push_back(e);
        end
        IR     = {op, 27'h0123456};
        Branch = br;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k == 4 + MW) Branch = ~br;
        end
        id++;
    endtask

    initial begin
        reset  = 1'b1;
        IR     = 32'd0;
        Branch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", w_obs, 35'd0);
        reset = 1'b0;
        #1;
        check("reset_state_after_release", w_obs, 35'd0);
        @(posedge clk);
        #1;

        do_instr(5'b00011, 4'b0000, 1'b0, 0);   // add
        do_instr(5'b00100, 4'b0001, 1'b0, 0);   // sub
        do_instr(5'b01001, 4'b0110, 1'b0, 0);   // ror
        do_instr(5'b01100, 4'b0010, 1'b0, 0);   // andi
        do_instr(5'b00001, 4'b0000, 1'b0, 0);   // ldi
        do_instr(5'b00000, 4'b0000, 1'b0, 0);   // ld
        do_instr(5'b00010, 4'b0000, 1'b0, 0);   // st
        do_instr(5'b01110, 4'b1000, 1'b0, 0);   // mul
        do_instr(5'b01111, 4'b1001, 1'b0, 0);   // div
        do_instr(5'b10000, 4'b1010, 1'b0, 0);   // neg
        do_instr(5'b10001, 4'b1011, 1'b0, 0);   // not
        do_instr(5'b10010, 4'b0000, 1'b1, 0);   // br taken, Branch drops in T4
        do_instr(5'b10010, 4'b0000, 1'b0, 0);   // br not taken, Branch rises in T4
        do_instr(5'b10011, 4'b0000, 1'b0, 0);   // jr
        do_instr(5'b10100, 4'b0000, 1'b0, 0);   // jal
        do_instr(5'b10101, 4'b0000, 1'b0, 0);   // in
        do_instr(5'b10110, 4'b0000, 1'b0, 0);   // out
        do_instr(5'b10111, 4'b0000, 1'b0, 0);   // mfhi
        do_instr(5'b11000, 4'b0000, 1'b0, 0);   // mflo
        do_instr(5'b11001, 4'b0000, 1'b0, 0);   // nop
        do_instr(5'b11111, 4'b0000, 1'b0, 0);   // undefined opcode

        // st interrupted by reset while in T6
        do_instr(5'b00010, 4'b0000, 1'b0, MW + 6);
        check("st_T6_strobes", w_obs, RUN | GRA | ROUT | MDRIN);
        #1 reset = 1'b1;
        #1 check("reset_mid_st_same_cycle", w_obs, 35'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_held_no_write", w_obs, 35'd0);
        end
        reset = 1'b0;
        #1 check("reset_state_after_abort", w_obs, 35'd0);
        @(posedge clk);
        #1;

        do_instr(5'b11010, 4'b0000, 1'b0, 0);   // halt
        for (int i = 0; i < 20; i++) begin
            check("halt_idle", w_obs, 35'd0);
            @(posedge clk);
            #1;
        end
        check("scoreboard_drain", 35'(sb.size()), 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired Moore control unit that drives every strobe the 32-bit single-bus datapath consumes.
- Fetches via PC/MAR/MDR, decodes the opcode in IR[31:27], and steps through per-instruction T-states.
- Asserts register-file selects through GRA/GRB/GRC with Rin/Rout, and an ALU op code.
- Sits beside the datapath: its inputs are IR and the CON FF Branch line; its outputs are the datapath's control inputs.

Parameters:
MEM_WAIT, 1, extra cycles that read/write are held before MDR capture or write completion (0..7).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
IR  in  32  instruction register value (IRval)
Branch  in  1  CON FF output, valid during the cycle Ra is on the bus
PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus-source strobes
PCin, MARin, MDRin, IRin, Yin, Zin, Zlowin, Zhighin, HIin, LOin, OutPortin  out  1 each  register load strobes
Rin, Rout, GRA, GRB, GRC  out  1 each  register-file select/enable
IncPc  out  1  ALU computes bus+1
read, write  out  1 each  memory strobes
mdr_read  out  2  MDR mux select: 00 bus, 01 memory
control  out  4  ALU opcode
run  out  1  high while executing; low in RESET_S and HALT_S

Behaviour:
- Opcodes, 5-bit: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Undefined opcodes execute as nop.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SHR 0100, SHL 0101, ROR 0110, ROL 0111, MUL 1000, DIV 1001, NEG 1010, NOT 1011.
- Reset: state goes to RESET_S. Every output is 0 (control=0000, mdr_read=00). First clock after reset deasserts moves to T0.
- Reset asserted mid-instruction aborts it immediately. No partial strobe is emitted after reset rises.
- Outputs decode combinationally from the state register and the opcode, so they are glitch-free relative to clk. Unlisted outputs are 0.
- Fetch:
  - T0: PCout MARin IncPc Zlowin.
  - T1 (1+MEM_WAIT cycles): read and mdr_read=01 held throughout; Zlowout PCin in the first cycle only; MDRin in the last cycle only.
  - T2: MDRout IRin.
  - Decode uses IR from T3 onward.
- R-type add..rol: T3 GRB Rout Yin; T4 GRC Rout control=op Zlowin; T5 Zlowout GRA Rin.
- addi/andi/ori: same as R-type, but T4 uses Cout instead of GRC Rout.
- ldi: T3 GRB BAout Yin; T4 Cout ADD Zlowin; T5 Zlowout GRA Rin.
- ld:
  - T3–T4 as ldi; T5 Zlowout MARin.
  - T6 (1+MEM_WAIT cycles): read mdr_read=01, with MDRin in the last cycle.
  - T7 MDRout GRA Rin.
- st:
  - T3–T5 as ld; T6 GRA Rout mdr_read=00 MDRin.
  - T7: write held 1+MEM_WAIT cycles.
- mul/div: T3 GRA Rout Yin; T4 GRB Rout control Zlowin Zhighin; T5 Zlowout LOin; T6 Zhighout HIin.
- neg/not: T3 GRB Rout control Zlowin; T4 Zlowout GRA Rin.
- br:
  - T3 GRA Rout; Branch is sampled into an internal flag at the end of T3.
  - T4 PCout Yin; T5 Cout ADD Zlowin.
  - T6 Zlowout PCin only if the flag is 1; otherwise T6 is an idle cycle.
- jr: T3 GRA Rout PCin.
- jal: T3 PCout GRB Rin; T4 GRA Rout PCin.
- in/out/mfhi/mflo, single step T3:
  - in: InPortout GRA Rin
  - out: GRA Rout OutPortin
  - mfhi: HIout GRA Rin
  - mflo: LOout GRA Rin
- Sequencing: nop returns from T2 to T0. After the last T-state the next state is T0.
- halt: T3 enters HALT_S. run=0 and all strobes are 0 until reset.
- Wait counter: 3 bits, loads MEM_WAIT on entry to any memory state, decrements each cycle, and the state advances at 0.
- MEM_WAIT=0 makes every memory state a single cycle.
- At most one bus source is asserted in any cycle (invariant).

Decomposition:
- Package cpu_pkg holds the opcode localparams, ALU code localparams, and the state enum (RESET_S, T0..T7, HALT_S).
- One sub-module, mem_wait_counter, implements the loadable down-counter and its done flag.
- The FSM and output decoder stay in control_sequencer.

Test Plan:
- MEM_WAIT=0, R1=5, R2=7, IR=add R3,R1,R2 → Zlowin with control=0000 in T4, GRA+Rin in T5, R3=12, back at T0 six cycles after T0.
- MEM_WAIT=2, ld R4,0x10(R0) → read high for 3 cycles in T6, MDRin only on the 3rd, R4 loaded at T7, BAout asserted only in T3.
- br with Branch=1 in T3 vs Branch=0 (Branch toggled in T4) → PCin in T6 only for the first case; the flag ignores Branch changes after T3.
- mul R2,R3 → LOin in T5, HIin in T6, Zhighin with Zlowin in T4, control=1000.
- Reset pulse during st T6 → all outputs 0 within the same cycle, no write pulse, RESET_S then T0 after release.
- halt followed by clocks → run=0 and no strobes for 20 cycles; unknown opcode 11111 → behaves as nop (T0 after T2).
